id_stage: RTL and testbench



---
 rtl/mips32_pkg.sv | 42 ++++
 rtl/mips32_regfile.sv | 40 ++++
 rtl/id_stage.sv | 123 ++++++++++++
 tb/tb_id_stage.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips32_pkg.sv
// Shared MIPS32 decode definitions: instruction field slices, opcodes and the
// instruction-class encoding used by the decode stage.
package mips32_pkg;

  localparam int unsigned OpcodeMsb = 31;
  localparam int unsigned OpcodeLsb = 26;
  localparam int unsigned RsMsb     = 25;
  localparam int unsigned RsLsb     = 21;
  localparam int unsigned RtMsb     = 20;
  localparam int unsigned RtLsb     = 16;
  localparam int unsigned ImmMsb    = 15;

  localparam logic [5:0] OpRrLast  = 6'b000101;
  localparam logic [5:0] OpLw      = 6'b001000;
  localparam logic [5:0] OpSw      = 6'b001001;
  localparam logic [5:0] OpRmFirst = 6'b001010;
  localparam logic [5:0] OpRmLast  = 6'b001100;
  localparam logic [5:0] OpBeqz    = 6'b001101;
  localparam logic [5:0] OpBnez    = 6'b001110;
  localparam logic [5:0] OpHlt     = 6'b111111;

  typedef enum logic [2:0] {
    ClsRrAlu   = 3'd0,
    ClsRmAlu   = 3'd1,
    ClsLoad    = 3'd2,
    ClsStore   = 3'd3,
    ClsBranch  = 3'd4,
    ClsHalt    = 3'd5,
    ClsIllegal = 3'd7
  } instr_class_e;

  function automatic instr_class_e decode_class(input logic [5:0] op);
    if (op <= OpRrLast) return ClsRrAlu;
    if (op >= OpRmFirst && op <= OpRmLast) return ClsRmAlu;
    if (op == OpLw) return ClsLoad;
    if (op == OpSw) return ClsStore;
    if (op == OpBeqz || op == OpBnez) return ClsBranch;
    if (op == OpHlt) return ClsHalt;
    return ClsIllegal;
  endfunction

endpackage

// File: rtl/mips32_regfile.sv
// Two-read, one-write register file with r0 hardwired to zero, write-to-read
// bypass and asynchronous clear.
module mips32_regfile #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  localparam int unsigned AddrW = $clog2(NREGS)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [AddrW-1:0] raddr_a_i,
  input  logic [AddrW-1:0] raddr_b_i,
  output logic [XLEN-1:0]  rdata_a_o,
  output logic [XLEN-1:0]  rdata_b_o,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [XLEN-1:0]  wdata_i
);

  logic [XLEN-1:0] mem_q [NREGS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else if (we_i && waddr_i != '0) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Writeback in the same cycle is forwarded so ID never sees a stale value.
  always_comb begin
    rdata_a_o = mem_q[raddr_a_i];
    if (raddr_a_i == '0) rdata_a_o = '0;
    else if (we_i && waddr_i == raddr_a_i) rdata_a_o = wdata_i;

    rdata_b_o = mem_q[raddr_b_i];
    if (raddr_b_i == '0) rdata_b_o = '0;
    else if (we_i && waddr_i == raddr_b_i) rdata_b_o = wdata_i;
  end

endmodule

// File: rtl/id_stage.sv
// MIPS32 instruction-decode stage: operand read, immediate extension, class
// decode, load-use stall detection and HLT latching into the ID/EX register.
module id_stage
  import mips32_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  localparam int unsigned AddrW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  npc_in,
  input  logic [XLEN-1:0]  ir_in,
  input  logic             valid_in,
  input  logic             flush,
  input  logic             ex_is_load,
  input  logic [AddrW-1:0] ex_rd,
  input  logic             wb_we,
  input  logic [AddrW-1:0] wb_addr,
  input  logic [XLEN-1:0]  wb_data,
  output logic             stall,
  output logic [XLEN-1:0]  npc_out,
  output logic [XLEN-1:0]  ir_out,
  output logic [XLEN-1:0]  a_out,
  output logic [XLEN-1:0]  b_out,
  output logic [XLEN-1:0]  imm_out,
  output logic [2:0]       type_out,
  output logic             valid_out,
  output logic             halted,
  output logic             illegal
);

  typedef enum logic {StRun, StHalted} state_e;

  state_e          state_q, state_d;
  instr_class_e    cls;
  logic [AddrW-1:0] rs, rt;
  logic [XLEN-1:0] rdata_a, rdata_b, imm_ext;
  logic            hazard, issue, illegal_d;

  logic [XLEN-1:0] npc_q, ir_q, a_q, b_q, imm_q;
  logic [2:0]      type_q;
  logic            valid_q, illegal_q;

  assign cls     = decode_class(ir_in[OpcodeMsb:OpcodeLsb]);
  assign rs      = ir_in[RsMsb:RsLsb];
  assign rt      = ir_in[RtMsb:RtLsb];
  assign imm_ext = {{(XLEN-ImmMsb-1){ir_in[ImmMsb]}}, ir_in[ImmMsb:0]};

  mips32_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .raddr_a_i (rs),
    .raddr_b_i (rt),
    .rdata_a_o (rdata_a),
    .rdata_b_o (rdata_b),
    .we_i      (wb_we),
    .waddr_i   (wb_addr),
    .wdata_i   (wb_data)
  );

  // Only RR ALU ops and stores consume rt as a source operand.
  assign hazard = ex_is_load && ex_rd != '0 &&
                  (ex_rd == rs || (ex_rd == rt && (cls == ClsRrAlu || cls == ClsStore)));

  always_comb begin
    state_d   = state_q;
    stall     = 1'b0;
    issue     = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      StRun: begin
        stall     = valid_in && !flush && hazard;
        issue     = valid_in && !flush && !stall && cls != ClsIllegal;
        illegal_d = valid_in && !flush && cls == ClsIllegal;
        if (valid_in && !flush && !stall && cls == ClsHalt) state_d = StHalted;
      end
      StHalted: stall = 1'b1;
      default:  state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StRun;
      npc_q     <= '0;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      type_q    <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= issue;
      illegal_q <= illegal_d;
      // Data registers hold across bubbles; valid_out alone marks them stale.
      if (issue) begin
        npc_q  <= npc_in;
        ir_q   <= ir_in;
        a_q    <= rdata_a;
        b_q    <= rdata_b;
        imm_q  <= imm_ext;
        type_q <= cls;
      end
    end
  end

  assign npc_out   = npc_q;
  assign ir_out    = ir_q;
  assign a_out     = a_q;
  assign b_out     = b_q;
  assign imm_out   = imm_q;
  assign type_out  = type_q;
  assign valid_out = valid_q;
  assign illegal   = illegal_q;
  assign halted    = (state_q == StHalted);

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed literal checks plus randomized
// traffic compared every cycle against a behavioural decode-stage model.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] npc_in = '0, ir_in = '0, wb_data = '0;
  logic        valid_in = 1'b0, flush = 1'b0, ex_is_load = 1'b0, wb_we = 1'b0;
  logic [4:0]  ex_rd = '0, wb_addr = '0;
  logic        stall, valid_out, halted, illegal;
  logic [31:0] npc_out, ir_out, a_out, b_out, imm_out;
  logic [2:0]  type_out;

  id_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .npc_in     (npc_in),
    .ir_in      (ir_in),
    .valid_in   (valid_in),
    .flush      (flush),
    .ex_is_load (ex_is_load),
    .ex_rd      (ex_rd),
    .wb_we      (wb_we),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .stall      (stall),
    .npc_out    (npc_out),
    .ir_out     (ir_out),
    .a_out      (a_out),
    .b_out      (b_out),
    .imm_out    (imm_out),
    .type_out   (type_out),
    .valid_out  (valid_out),
    .halted     (halted),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit started = 1'b0;

  // Behavioural model state
  logic [31:0] m_regs [32];
  logic [31:0] e_npc, e_ir, e_a, e_b, e_imm;
  logic [2:0]  e_type;
  logic        e_valid, e_halted, e_illegal;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int class_of(input logic [31:0] ir);
    int op;
    op = int'(ir[31:26]);
    if (op <= 5) return 0;
    if (op >= 10 && op <= 12) return 1;
    if (op == 8) return 2;
    if (op == 9) return 3;
    if (op == 13 || op == 14) return 4;
    if (op == 63) return 5;
    return 7;
  endfunction

  function automatic logic m_stall();
    int c;
    logic [4:0] rs, rt;
    c  = class_of(ir_in);
    rs = ir_in[25:21];
    rt = ir_in[20:16];
    if (e_halted) return 1'b1;
    return valid_in && !flush && ex_is_load && ex_rd != 0 &&
           (ex_rd == rs || (ex_rd == rt && (c == 0 || c == 3)));
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] r);
    if (r == 0) return 32'h0;
    if (wb_we && wb_addr == r) return wb_data;
    return m_regs[r];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    e_npc = '0; e_ir = '0; e_a = '0; e_b = '0; e_imm = '0; e_type = '0;
    e_valid = 1'b0; e_halted = 1'b0; e_illegal = 1'b0;
  endtask

  task automatic model_step();
    int c;
    logic st, go;
    logic [31:0] a, b;
    if (!rst_n) return;
    c  = class_of(ir_in);
    st = m_stall();
    a  = m_read(ir_in[25:21]);
    b  = m_read(ir_in[20:16]);
    go = valid_in && !flush && !st && c != 7 && !e_halted;
    e_illegal = !e_halted && valid_in && !flush && c == 7;
    e_valid   = go;
    if (go) begin
      e_npc  = npc_in;
      e_ir   = ir_in;
      e_a    = a;
      e_b    = b;
      e_imm  = {{16{ir_in[15]}}, ir_in[15:0]};
      e_type = 3'(c);
    end
    if (!e_halted && valid_in && !flush && !st && c == 5) e_halted = 1'b1;
    if (wb_we && wb_addr != 0) m_regs[wb_addr] = wb_data;
  endtask

  // Advance one clock: model follows the edge, then settle 1 time unit.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic [31:0] ir, input logic v, input logic fl, input logic ld,
                       input logic [4:0] rd, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd);
    npc_in     = npc_in + 32'd4;
    ir_in      = ir;
    valid_in   = v;
    flush      = fl;
    ex_is_load = ld;
    ex_rd      = rd;
    wb_we      = we;
    wb_addr    = wa;
    wb_data    = wd;
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        check("stall", {31'b0, stall}, {31'b0, m_stall()});
        check("valid_out", {31'b0, valid_out}, {31'b0, e_valid});
        check("halted", {31'b0, halted}, {31'b0, e_halted});
        check("illegal", {31'b0, illegal}, {31'b0, e_illegal});
        if (e_valid) begin
          check("npc_out", npc_out, e_npc);
          check("ir_out", ir_out, e_ir);
          check("a_out", a_out, e_a);
          check("b_out", b_out, e_b);
          check("imm_out", imm_out, e_imm);
          check("type_out", {29'b0, type_out}, {29'b0, e_type});
        end
      end
    end
  end

  int ops [13] = '{0, 1, 2, 3, 4, 5, 8, 9, 10, 11, 12, 13, 14};

  initial begin
    model_reset();
    #2 rst_n = 1'b0;
    model_reset();
    started = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_valid", {31'b0, valid_out}, 32'd0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    check("rst_illegal", {31'b0, illegal}, 32'd0);
    check("rst_npc", npc_out, 32'd0);

    // Same-cycle writeback bypass onto rs
    drive(mk(6'd0, 5'd5, 5'd0, 16'h0020), 1, 0, 0, 0, 1, 5'd5, 32'h0000_00AA);
    tick();
    check("bypass_a", a_out, 32'h0000_00AA);
    check("bypass_valid", {31'b0, valid_out}, 32'd1);

    // ADDI decode
    drive(32'h2822_FFFF, 1, 0, 0, 0, 0, 0, 0);
    tick();
    check("addi_type", {29'b0, type_out}, 32'd1);
    check("addi_imm", imm_out, 32'hFFFF_FFFF);
    check("addi_valid", {31'b0, valid_out}, 32'd1);

    // Load-use on rs stalls, then issues once the load is gone
    drive(mk(6'd0, 5'd3, 5'd4, 16'h0020), 1, 0, 1, 5'd3, 0, 0, 0);
    #1 check("lu_stall", {31'b0, stall}, 32'd1);
    tick();
    check("lu_bubble", {31'b0, valid_out}, 32'd0);
    drive(mk(6'd0, 5'd3, 5'd4, 16'h0020), 1, 0, 0, 5'd3, 0, 0, 0);
    #1 check("lu_nostall", {31'b0, stall}, 32'd0);
    tick();
    check("lu_issue", {31'b0, valid_out}, 32'd1);

    // rt match only counts for RR ALU and STORE
    drive(mk(6'b001000, 5'd1, 5'd3, 16'h0004), 1, 0, 1, 5'd3, 0, 0, 0);
    #1 check("lw_rt_nostall", {31'b0, stall}, 32'd0);
    tick();
    drive(mk(6'b001001, 5'd1, 5'd3, 16'h0004), 1, 0, 1, 5'd3, 0, 0, 0);
    #1 check("sw_rt_stall", {31'b0, stall}, 32'd1);
    tick();
    drive(mk(6'd0, 5'd0, 5'd0, 16'h0020), 1, 0, 1, 5'd0, 0, 0, 0);
    #1 check("rd0_nostall", {31'b0, stall}, 32'd0);
    tick();

    // Flush beats the hazard
    drive(mk(6'd0, 5'd3, 5'd4, 16'h0020), 1, 1, 1, 5'd3, 0, 0, 0);
    #1 check("flush_stall", {31'b0, stall}, 32'd0);
    tick();
    check("flush_bubble", {31'b0, valid_out}, 32'd0);

    // r0 ignores writes
    drive(mk(6'd0, 5'd0, 5'd5, 16'h0020), 1, 0, 0, 0, 1, 5'd0, 32'h0000_1234);
    tick();
    check("r0_bypass", a_out, 32'd0);
    check("r5_held", b_out, 32'h0000_00AA);
    drive(mk(6'd0, 5'd0, 5'd0, 16'h0020), 1, 0, 0, 0, 0, 0, 0);
    tick();
    check("r0_read", a_out, 32'd0);

    // Illegal opcode pulses once
    drive(mk(6'b010000, 5'd0, 5'd0, 16'h0000), 1, 0, 0, 0, 0, 0, 0);
    tick();
    check("ill_pulse", {31'b0, illegal}, 32'd1);
    check("ill_bubble", {31'b0, valid_out}, 32'd0);
    drive(32'h0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check("ill_clear", {31'b0, illegal}, 32'd0);

    // Flushed HLT is squashed; real HLT halts
    drive(32'hFC00_0000, 1, 1, 0, 0, 0, 0, 0);
    tick();
    check("hlt_flush", {31'b0, halted}, 32'd0);
    drive(32'hFC00_0000, 1, 0, 0, 0, 0, 0, 0);
    tick();
    check("hlt_type", {29'b0, type_out}, 32'd5);
    check("hlt_valid", {31'b0, valid_out}, 32'd1);
    check("hlt_halted", {31'b0, halted}, 32'd1);
    drive(mk(6'd0, 5'd1, 5'd2, 16'h0020), 1, 0, 0, 0, 0, 0, 0);
    #1 check("hlt_stall", {31'b0, stall}, 32'd1);
    tick();
    check("hlt_bubble", {31'b0, valid_out}, 32'd0);

    // Reset from HALTED clears state and the register file
    rst_n = 1'b0;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    drive(mk(6'd0, 5'd5, 5'd0, 16'h0020), 1, 0, 0, 0, 0, 0, 0);
    #1 check("post_rst_stall", {31'b0, stall}, 32'd0);
    tick();
    check("post_rst_halted", {31'b0, halted}, 32'd0);
    check("post_rst_r5", a_out, 32'd0);

    // Randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [5:0] op;
      if (cyc % 250 == 249) begin
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
      end
      if ($urandom_range(0, 199) == 0) op = 6'b111111;
      else if ($urandom_range(0, 9) == 0) op = 6'($urandom);
      else op = 6'(ops[$urandom_range(0, 12)]);
      drive(mk(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)),
            $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)),
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
      tick();
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
